// File: rtl/wb_write_sequencer.sv
// Write-back sequencer: queues register writes and replays each one as a
// setup cycle followed by a one-cycle writeM pulse, with read-port bypass.
module wb_write_sequencer #(
   parameter int WORD_SIZE = 16,
   parameter int IDX_W     = 2,
   parameter int DEPTH     = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 wb_valid,
   output logic                 wb_ready,
   input  logic [IDX_W-1:0]     wb_idx,
   input  logic [WORD_SIZE-1:0] wb_data,
   output logic                 writeM,
   output logic [IDX_W-1:0]     writeIdx,
   output logic [WORD_SIZE-1:0] writeData,
   input  logic [IDX_W-1:0]     r1Idx,
   input  logic [IDX_W-1:0]     r2Idx,
   output logic                 r1_pending,
   output logic [WORD_SIZE-1:0] r1_fwd,
   output logic                 r2_pending,
   output logic [WORD_SIZE-1:0] r2_fwd,
   output logic                 busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_STROBE = 2'd2;

   logic [1:0]           r_state;
   logic [1:0]           w_state_nx;
   logic [PW-1:0]        r_head;
   logic [PW-1:0]        r_tail;
   logic [PW-1:0]        w_head_nx;
   logic [CW-1:0]        r_count;
   logic [CW-1:0]        w_remain;
   logic [CW-1:0]        w_count_nx;
   logic [IDX_W-1:0]     r_idx_mem [DEPTH];
   logic [WORD_SIZE-1:0] r_data_mem [DEPTH];
   logic                 w_push;
   logic                 w_pop;
   logic                 w_load;
   logic [IDX_W-1:0]     w_ld_idx;
   logic [WORD_SIZE-1:0] w_ld_data;
   logic                 r_wm;
   logic [IDX_W-1:0]     r_widx;
   logic [WORD_SIZE-1:0] r_wdata;
   logic [PW-1:0]        w_p;
   logic                 w_r1_p;
   logic                 w_r2_p;
   logic [WORD_SIZE-1:0] w_r1_f;
   logic [WORD_SIZE-1:0] w_r2_f;

   assign wb_ready   = (r_count < C_DEPTH);
   assign w_push     = wb_valid && wb_ready;
   assign w_pop      = (r_state == S_STROBE);
   assign w_head_nx  = w_pop ? r_head + 1'b1 : r_head;
   assign w_remain   = r_count - {{(CW-1){1'b0}}, w_pop};
   assign w_count_nx = w_remain + {{(CW-1){1'b0}}, w_push};

   always_comb begin
      w_state_nx = r_state;
      unique case (1'b1)
         (r_state == S_IDLE):
            if (r_count != '0 || w_push)
               w_state_nx = S_SETUP;
         (r_state == S_SETUP):
            w_state_nx = S_STROBE;
         (r_state == S_STROBE):
            w_state_nx = (w_count_nx != '0) ? S_SETUP : S_IDLE;
         default:
            w_state_nx = S_IDLE;
      endcase
   end

   // With nothing left behind the popped head, the new head is this cycle's push.
   assign w_load    = (w_state_nx == S_SETUP);
   assign w_ld_idx  = (w_remain != '0) ? r_idx_mem[w_head_nx] : wb_idx;
   assign w_ld_data = (w_remain != '0) ? r_data_mem[w_head_nx] : wb_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_wm    <= 1'b0;
         r_widx  <= '0;
         r_wdata <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_idx_mem[i]  <= '0;
            r_data_mem[i] <= '0;
         end
      end else begin
         r_state <= w_state_nx;
         r_head  <= w_head_nx;
         r_count <= w_count_nx;
         r_wm    <= (w_state_nx == S_STROBE);
         if (w_push) begin
            r_idx_mem[r_tail]  <= wb_idx;
            r_data_mem[r_tail] <= wb_data;
            r_tail             <= r_tail + 1'b1;
         end
         if (w_load) begin
            r_widx  <= w_ld_idx;
            r_wdata <= w_ld_data;
         end
      end
   end

   // Oldest to youngest, so a later match overrides an earlier one.
   always_comb begin
      w_r1_p = 1'b0;
      w_r2_p = 1'b0;
      w_r1_f = '0;
      w_r2_f = '0;
      w_p    = r_head;
      for (int i = 0; i < DEPTH; i++) begin
         w_p = r_head + PW'(i);
         if (CW'(i) < r_count) begin
            if (r_idx_mem[w_p] == r1Idx) begin
               w_r1_p = 1'b1;
               w_r1_f = r_data_mem[w_p];
            end
            if (r_idx_mem[w_p] == r2Idx) begin
               w_r2_p = 1'b1;
               w_r2_f = r_data_mem[w_p];
            end
         end
      end
   end

   assign writeM     = r_wm;
   assign writeIdx   = r_widx;
   assign writeData  = r_wdata;
   assign r1_pending = w_r1_p;
   assign r1_fwd     = w_r1_f;
   assign r2_pending = w_r2_p;
   assign r2_fwd     = w_r2_f;
   assign busy       = (r_state != S_IDLE) || (r_count != '0);

endmodule
